// File: rtl/reaction_round_controller_pkg.sv
// reaction_round_controller_pkg: state encodings, BCD limit and LFSR step shared by the round controller
package reaction_round_controller_pkg;
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_TIMING = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd3;
  localparam logic [2:0] S_FOUL   = 3'd4;
  localparam logic [2:0] S_HIGH   = 3'd5;
  localparam logic [15:0] BCD_MAX = 16'h9999;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/reaction_round_controller_if.sv
// reaction_round_controller_if: buttons, timer and display signals between the controller and its surroundings
interface reaction_round_controller_if;
  logic tick, start, stop, show_high, elapsed_ovf;
  logic [15:0] elapsed;
  logic led, bcd_clear, bcd_run, result_valid, new_record, foul, hs_show;
  logic [15:0] result, high_score;
  modport master (
    output tick, start, stop, show_high, elapsed, elapsed_ovf,
    input  led, bcd_clear, bcd_run, result, result_valid, new_record, foul, hs_show, high_score
  );
  modport slave (
    input  tick, start, stop, show_high, elapsed, elapsed_ovf,
    output led, bcd_clear, bcd_run, result, result_valid, new_record, foul, hs_show, high_score
  );
endinterface

// File: rtl/reaction_round_controller_lfsr.sv
// reaction_round_controller_lfsr: free-running 16-bit Fibonacci LFSR for the random hold-off
module reaction_round_controller_lfsr
  import reaction_round_controller_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] q
);
  logic [15:0] q_q, q_d;
  always_comb q_d = lfsr_next(q_q);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) q_q <= SEED;
    else q_q <= q_d;
  end
  assign q = q_q;
endmodule

// File: rtl/reaction_round_controller.sv
// reaction_round_controller: sequences a reaction round (hold-off, go lamp, timing, capture) and tracks the best score
module reaction_round_controller
  import reaction_round_controller_pkg::*;
#(
  parameter int          DELAY_MIN  = 1000,
  parameter int          DELAY_BITS = 11,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input logic clock,
  input logic reset,
  reaction_round_controller_if.slave bus
);
  localparam int CW = DELAY_BITS + 1;
  logic [2:0] state_q, state_d;
  logic [CW-1:0] delay_cnt_q, delay_cnt_d;
  logic [15:0] result_q, result_d, high_score_q, high_score_d, lfsr;
  logic start_q, stop_q, bcd_clear_q, bcd_clear_d, new_record_q, new_record_d;
  logic start_rise, stop_rise, unused_lfsr;
  reaction_round_controller_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clock(clock), .reset(reset), .q(lfsr));
  assign unused_lfsr = ^lfsr[15:DELAY_BITS];
  assign start_rise = bus.start & ~start_q;
  assign stop_rise = bus.stop & ~stop_q;
  always_comb begin
    state_d = state_q;
    delay_cnt_d = delay_cnt_q;
    result_d = result_q;
    high_score_d = high_score_q;
    new_record_d = new_record_q;
    bcd_clear_d = 1'b0;
    case (state_q)
      S_IDLE: state_d = start_rise ? S_ARMED : bus.show_high ? S_HIGH : S_IDLE;
      S_ARMED: begin
        state_d = stop_rise ? S_FOUL : delay_cnt_q == '0 ? S_TIMING : S_ARMED;
        if (bus.tick && delay_cnt_q != '0) delay_cnt_d = delay_cnt_q - CW'(1);
      end
      S_TIMING: begin
        if (stop_rise) begin
          state_d = S_DONE;
          result_d = bus.elapsed;
          new_record_d = bus.elapsed < high_score_q;
          high_score_d = new_record_d ? bus.elapsed : high_score_q;
        end else if (bus.elapsed_ovf) begin
          state_d = S_FOUL;
          result_d = BCD_MAX;
        end
      end
      S_DONE, S_FOUL: state_d = start_rise ? S_ARMED : state_q;
      S_HIGH: state_d = bus.show_high ? S_HIGH : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // every entry into ARMED clears the timer and draws a fresh hold-off
    if (state_d == S_ARMED && state_q != S_ARMED) begin
      bcd_clear_d = 1'b1;
      delay_cnt_d = CW'(DELAY_MIN) + CW'(lfsr[DELAY_BITS-1:0]);
    end
    if (state_d != S_DONE) new_record_d = 1'b0;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      delay_cnt_q <= '0;
      result_q <= 16'h0000;
      high_score_q <= BCD_MAX;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      bcd_clear_q <= 1'b0;
      new_record_q <= 1'b0;
    end else begin
      state_q <= state_d;
      delay_cnt_q <= delay_cnt_d;
      result_q <= result_d;
      high_score_q <= high_score_d;
      start_q <= bus.start;
      stop_q <= bus.stop;
      bcd_clear_q <= bcd_clear_d;
      new_record_q <= new_record_d;
    end
  end
  assign bus.led = state_q == S_TIMING || state_q == S_DONE;
  assign bus.bcd_run = state_q == S_TIMING;
  assign bus.result_valid = state_q == S_DONE;
  assign bus.foul = state_q == S_FOUL;
  assign bus.hs_show = state_q == S_HIGH;
  assign bus.bcd_clear = bcd_clear_q;
  assign bus.new_record = new_record_q;
  assign bus.result = result_q;
  assign bus.high_score = high_score_q;
endmodule
